// File: rtl/fifo_pkg.sv
// Shared constants and helpers that keep sync_fifo and its write-side controller
// in agreement on geometry.
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_level_ctr.sv
// Up/down occupancy counter saturating at 0 and MAX. An inc and a dec in the same
// cycle cancel each other.
module fifo_level_ctr #(
    parameter int MAX = 16,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] level
);

    localparam logic [W-1:0] MAX_L = W'(MAX);

    logic inc_ok;
    logic dec_ok;

    assign inc_ok = inc && (level != MAX_L);
    assign dec_ok = dec && (level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (inc_ok && !dec_ok) begin
            level <= level + W'(1);
        end else if (dec_ok && !inc_ok) begin
            level <= level - W'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side front end for sync_fifo: a one-entry skid register feeding wr_en/wdata,
// plus a shadow occupancy count so a write is never issued into a full FIFO.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int LVL_W     = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_wdata,
    input  logic             fifo_rd_en,
    input  logic             fifo_wr_error,
    output logic [LVL_W-1:0] level,
    output logic             almost_full,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    input  logic             clr
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             drain;
    logic             acc;
    logic             rd_obs;

    // drain and s_ready depend only on flops, so s_valid never reaches s_ready.
    assign drain       = hold_valid && (level < DEPTH_L);
    assign s_ready     = !hold_valid || drain;
    assign acc         = s_valid && s_ready;
    assign fifo_wr_en  = drain;
    assign fifo_wdata  = hold_data;
    assign rd_obs      = fifo_rd_en && (level != '0);
    assign almost_full = (level >= AF_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (acc) begin
            hold_valid <= 1'b1;
            hold_data  <= s_data;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    fifo_level_ctr #(
        .MAX (DEPTH),
        .W   (LVL_W)
    ) u_level (
        .clk   (clk),
        .rst   (rst),
        .inc   (drain),
        .dec   (rd_obs),
        .level (level)
    );

    // A set condition in the same cycle as clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (fifo_wr_error)              ovf_sticky <= 1'b1;
            else if (clr)                   ovf_sticky <= 1'b0;
            if (fifo_rd_en && level == '0)  udf_sticky <= 1'b1;
            else if (clr)                   udf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at DEPTH=4, WIDTH=8, AF_THRESH=2; each step sets
// inputs #1 after a rising edge and checks outputs before the next edge.
module tb_fifo_wr_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int LVL_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_wdata;
    logic             fifo_rd_en = 1'b0;
    logic             fifo_wr_error = 1'b0;
    logic [LVL_W-1:0] level;
    logic             almost_full;
    logic             ovf_sticky;
    logic             udf_sticky;
    logic             clr = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;
    int n_wr   = 0;

    fifo_wr_ctrl #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AF_THRESH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wdata    (fifo_wdata),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_wr_error (fifo_wr_error),
        .level         (level),
        .almost_full   (almost_full),
        .ovf_sticky    (ovf_sticky),
        .udf_sticky    (udf_sticky),
        .clr           (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [7:0] data,
                          input logic [2:0] lvl);
        chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'(en));
        if (en) chk({tag, "_wdata"}, 32'(fifo_wdata), 32'(data));
        chk({tag, "_level"}, 32'(level), 32'(lvl));
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_udf", 32'(udf_sticky), 32'd0);

        // Streaming 0x11, 0x22, 0x33 with no reads
        rst = 1'b0;
        s_valid = 1'b1; s_data = 8'h11;
        chk("str0_wr_en", 32'(fifo_wr_en), 32'd0);
        tick();
        chk_wr("str1", 1'b1, 8'h11, 3'd0);
        chk("str1_af", 32'(almost_full), 32'd0);
        s_data = 8'h22;
        tick();
        chk_wr("str2", 1'b1, 8'h22, 3'd1);
        chk("str2_af", 32'(almost_full), 32'd0);
        s_data = 8'h33;
        tick();
        chk_wr("str3", 1'b1, 8'h33, 3'd2);
        chk("str3_af", 32'(almost_full), 32'd1);
        s_valid = 1'b0;
        tick();
        chk_wr("str4", 1'b0, 8'h00, 3'd3);
        chk("str4_af", 32'(almost_full), 32'd1);

        // Async reset mid-cycle while a word is held and s_valid stays high
        s_valid = 1'b1; s_data = 8'h55;
        tick();
        chk("pre_rst_wr_en", 32'(fifo_wr_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        chk("arst_wdata", 32'(fifo_wdata), 32'd0);
        tick();
        chk("arst_hold_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("arst_hold_level", 32'(level), 32'd0);

        // Fill/stall: six words A1..A6 offered back to back, no reads
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            s_data = 8'hA0 + 8'(i);
            if (fifo_wr_en) n_wr++;
            if (s_ready !== 1'b1) break;
            tick();
        end
        // Loop exits at the stalled step: A5 held, A6 offered, level full
        chk("fill_wr_count", 32'(n_wr), 32'd4);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_s_ready", 32'(s_ready), 32'd0);
        chk("fill_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("fill_held", 32'(fifo_wdata), 32'hA5);
        chk("fill_ovf", 32'(ovf_sticky), 32'd0);
        chk("fill_af", 32'(almost_full), 32'd1);
        tick();
        chk_wr("stall", 1'b0, 8'h00, 3'd4);
        chk("stall_s_ready", 32'(s_ready), 32'd0);

        // Release: one read frees a slot; the held word drains a cycle later
        fifo_rd_en = 1'b1;
        chk("rel_same_cycle_wr_en", 32'(fifo_wr_en), 32'd0);
        tick();
        fifo_rd_en = 1'b0;
        chk_wr("rel1", 1'b1, 8'hA5, 3'd3);
        chk("rel1_s_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk_wr("rel2", 1'b0, 8'h00, 3'd4);
        chk("rel2_s_ready", 32'(s_ready), 32'd0);
        chk("rel2_held", 32'(fifo_wdata), 32'hA6);

        // Walk down to level 2: read+drain at 3 holds, then a plain read
        fifo_rd_en = 1'b1;
        tick();
        chk_wr("dn1", 1'b1, 8'hA6, 3'd3);
        tick();
        chk_wr("dn2", 1'b0, 8'h00, 3'd3);
        tick();
        fifo_rd_en = 1'b0;
        chk("dn3_level", 32'(level), 32'd2);

        // Concurrent drain and read at level 2
        s_valid = 1'b1; s_data = 8'hB1;
        tick();
        s_valid = 1'b0; fifo_rd_en = 1'b1;
        chk_wr("conc", 1'b1, 8'hB1, 3'd2);
        tick();
        chk_wr("conc_after", 1'b0, 8'h00, 3'd2);

        // Drain to empty
        tick();
        chk("empty1_level", 32'(level), 32'd1);
        tick();
        chk("empty0_level", 32'(level), 32'd0);
        chk("empty0_udf", 32'(udf_sticky), 32'd0);

        // Underflow: read at level 0 sets udf and level stays 0
        tick();
        fifo_rd_en = 1'b0;
        chk("udf_set", 32'(udf_sticky), 32'd1);
        chk("udf_level", 32'(level), 32'd0);
        clr = 1'b1;
        tick();
        chk("udf_clr", 32'(udf_sticky), 32'd0);

        // Overflow error with clr in the same cycle: set wins
        fifo_wr_error = 1'b1;
        tick();
        fifo_wr_error = 1'b0;
        chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
        tick();
        chk("ovf_clr", 32'(ovf_sticky), 32'd0);

        // udf set also wins against clr
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0; clr = 1'b0;
        chk("udf_set_wins", 32'(udf_sticky), 32'd1);
        tick();
        chk("udf_hold", 32'(udf_sticky), 32'd1);
        chk("final_level", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
